// File: rtl/demux_l1_if.sv
// -----------------------------------------------------------------------------
// demux_l1_if
// Bundles the serial byte stream input and the four reconstructed lane outputs
// of the lane demultiplexer.
//   dataIn / validIn / flush   : serial stream and flush request (master drives)
//   dataOut0..3 / validOut0..3 : reconstructed lanes, one-cycle valid pulses
//                                (slave drives)
// -----------------------------------------------------------------------------
interface demux_l1_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dataIn;
    logic             validIn;
    logic             flush;
    logic [WIDTH-1:0] dataOut0;
    logic [WIDTH-1:0] dataOut1;
    logic [WIDTH-1:0] dataOut2;
    logic [WIDTH-1:0] dataOut3;
    logic             validOut0;
    logic             validOut1;
    logic             validOut2;
    logic             validOut3;

    modport master (
        output dataIn, validIn, flush,
        input  dataOut0, dataOut1, dataOut2, dataOut3,
        input  validOut0, validOut1, validOut2, validOut3
    );

    modport slave (
        input  dataIn, validIn, flush,
        output dataOut0, dataOut1, dataOut2, dataOut3,
        output validOut0, validOut1, validOut2, validOut3
    );
endinterface

// File: rtl/demux_l1.sv
// -----------------------------------------------------------------------------
// demux_l1
// Un-stripes a serial byte stream back into four parallel lanes. Valid bytes
// are collected round-robin into lanes 0..3; the completed word is presented
// one cycle after its last byte with a one-cycle valid pulse per lane. A flush
// forces out a partially collected word, zeroing the lanes it does not cover.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high; clears pointer, holding regs, outputs
//   bus    : demux_l1_if.slave (dataIn/validIn/flush in, dataOut0..3 and
//            validOut0..3 out, all outputs registered)
// -----------------------------------------------------------------------------
module demux_l1 #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    demux_l1_if.slave   bus
);

    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] hold_q [3];
    logic [WIDTH-1:0] hold_d [3];
    logic [WIDTH-1:0] dout_q [4];
    logic [WIDTH-1:0] dout_d [4];
    logic [3:0]       vout_q, vout_d;

    // Candidate word as it would look if emitted this cycle: held bytes with
    // the incoming byte dropped into the lane the pointer selects.
    logic [WIDTH-1:0] lane [4];
    logic [2:0]       cnt;
    logic [3:0]       mask;
    logic             emit;

    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        dout_d = dout_q;
        vout_d = 4'b0000;
        mask   = 4'b0000;

        // Number of bytes the word would contain including this cycle's byte.
        cnt  = {1'b0, ptr_q} + {2'b00, bus.validIn};
        emit = bus.flush ? (cnt != 3'd0) : (bus.validIn && (ptr_q == 2'd3));

        for (int k = 0; k < 3; k++) begin
            lane[k] = hold_q[k];
        end
        lane[3] = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.validIn && (ptr_q == 2'(k))) begin
                lane[k] = bus.dataIn;
            end
            mask[k] = (3'(k) < cnt);
        end

        if (emit) begin
            ptr_d  = 2'd0;
            vout_d = mask;
            // Lanes not covered by a partial word read as zero so stale
            // holding-register contents never leak out.
            for (int k = 0; k < 4; k++) begin
                dout_d[k] = mask[k] ? lane[k] : '0;
            end
        end else if (bus.validIn) begin
            // Not emitting implies ptr_q < 3, so the byte goes to a hold reg.
            ptr_d = ptr_q + 2'd1;
            for (int k = 0; k < 3; k++) begin
                if (ptr_q == 2'(k)) begin
                    hold_d[k] = bus.dataIn;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= 2'd0;
            vout_q <= 4'b0000;
            for (int k = 0; k < 3; k++) begin
                hold_q[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                dout_q[k] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            vout_q <= vout_d;
            hold_q <= hold_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dataOut0  = dout_q[0];
    assign bus.dataOut1  = dout_q[1];
    assign bus.dataOut2  = dout_q[2];
    assign bus.dataOut3  = dout_q[3];
    assign bus.validOut0 = vout_q[0];
    assign bus.validOut1 = vout_q[1];
    assign bus.validOut2 = vout_q[2];
    assign bus.validOut3 = vout_q[3];

endmodule

// File: tb/tb_demux_l1.sv
// -----------------------------------------------------------------------------
// tb_demux_l1
// Directed, table-driven bench for demux_l1. Each table row gives the inputs
// for one clock and the outputs expected right after that clock edge.
// -----------------------------------------------------------------------------
module tb_demux_l1;

    logic clk;
    logic reset;

    demux_l1_if #(.WIDTH(8)) bus ();

    demux_l1 #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vi;
        logic       fl;
        logic [7:0] din;
        logic [3:0] ev;   // bit k = expected validOutk
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic vi, logic fl, logic [7:0] din, logic [3:0] ev,
                                logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
        vec_t v;
        v.vi = vi; v.fl = fl; v.din = din; v.ev = ev;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        return v;
    endfunction

    task automatic check_out(input string name, input logic [3:0] ev,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [35:0] act, exp;
        act = {bus.validOut3, bus.validOut2, bus.validOut1, bus.validOut0,
               bus.dataOut0, bus.dataOut1, bus.dataOut2, bus.dataOut3};
        exp = {ev, e0, e1, e2, e3};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h %h %h %h, want v=%b d=%h %h %h %h", name,
                     act[35:32], act[31:24], act[23:16], act[15:8], act[7:0],
                     ev, e0, e1, e2, e3);
        end
    endtask

    // Drive one row at the falling edge, sample just after the rising edge.
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        bus.validIn = v.vi;
        bus.flush   = v.fl;
        bus.dataIn  = v.din;
        @(posedge clk);
        #1;
        check_out(name, v.ev, v.e0, v.e1, v.e2, v.e3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // word 1: A1..D4
        vecs.push_back(mk(1,0,8'hA1,4'h0,8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'hB2,4'h0,8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'hC3,4'h0,8'h00,8'h00,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'hD4,4'hF,8'hA1,8'hB2,8'hC3,8'hD4));
        vecs.push_back(mk(0,0,8'h00,4'h0,8'hA1,8'hB2,8'hC3,8'hD4));
        // back-to-back 01..08
        vecs.push_back(mk(1,0,8'h01,4'h0,8'hA1,8'hB2,8'hC3,8'hD4));
        vecs.push_back(mk(1,0,8'h02,4'h0,8'hA1,8'hB2,8'hC3,8'hD4));
        vecs.push_back(mk(1,0,8'h03,4'h0,8'hA1,8'hB2,8'hC3,8'hD4));
        vecs.push_back(mk(1,0,8'h04,4'hF,8'h01,8'h02,8'h03,8'h04));
        vecs.push_back(mk(1,0,8'h05,4'h0,8'h01,8'h02,8'h03,8'h04));
        vecs.push_back(mk(1,0,8'h06,4'h0,8'h01,8'h02,8'h03,8'h04));
        vecs.push_back(mk(1,0,8'h07,4'h0,8'h01,8'h02,8'h03,8'h04));
        vecs.push_back(mk(1,0,8'h08,4'hF,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(0,0,8'h00,4'h0,8'h05,8'h06,8'h07,8'h08));
        // gaps inside a word
        vecs.push_back(mk(1,0,8'h11,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(0,0,8'hEE,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(0,0,8'hEE,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(0,0,8'hEE,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(1,0,8'h22,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(1,0,8'h33,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(0,0,8'hEE,4'h0,8'h05,8'h06,8'h07,8'h08));
        vecs.push_back(mk(1,0,8'h44,4'hF,8'h11,8'h22,8'h33,8'h44));
        // flush alone after two bytes (hold2 still has stale 33)
        vecs.push_back(mk(1,0,8'h5A,4'h0,8'h11,8'h22,8'h33,8'h44));
        vecs.push_back(mk(1,0,8'h6B,4'h0,8'h11,8'h22,8'h33,8'h44));
        vecs.push_back(mk(0,1,8'h00,4'h3,8'h5A,8'h6B,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'h7C,4'h0,8'h5A,8'h6B,8'h00,8'h00));
        vecs.push_back(mk(0,1,8'h00,4'h1,8'h7C,8'h00,8'h00,8'h00));
        // flush together with a byte
        vecs.push_back(mk(1,0,8'h10,4'h0,8'h7C,8'h00,8'h00,8'h00));
        vecs.push_back(mk(1,1,8'h20,4'h3,8'h10,8'h20,8'h00,8'h00));
        // flush with nothing collected: no pulse, data held
        vecs.push_back(mk(0,1,8'h00,4'h0,8'h10,8'h20,8'h00,8'h00));
        // flush with the 4th byte behaves as a full word
        vecs.push_back(mk(1,0,8'h31,4'h0,8'h10,8'h20,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'h32,4'h0,8'h10,8'h20,8'h00,8'h00));
        vecs.push_back(mk(1,0,8'h33,4'h0,8'h10,8'h20,8'h00,8'h00));
        vecs.push_back(mk(1,1,8'h34,4'hF,8'h31,8'h32,8'h33,8'h34));
        // flush with the first byte of a word
        vecs.push_back(mk(1,1,8'h99,4'h1,8'h99,8'h00,8'h00,8'h00));
        vecs.push_back(mk(0,0,8'h00,4'h0,8'h99,8'h00,8'h00,8'h00));

        bus.validIn = 1'b0;
        bus.flush   = 1'b0;
        bus.dataIn  = 8'h00;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a word: partial bytes are discarded and the
        // outputs clear without waiting for a clock edge.
        apply("mid_ee", mk(1,0,8'hEE,4'h0,8'h99,8'h00,8'h00,8'h00));
        apply("mid_ff", mk(1,0,8'hFF,4'h0,8'h99,8'h00,8'h00,8'h00));
        @(negedge clk);
        bus.validIn = 1'b0;
        bus.flush   = 1'b0;
        reset       = 1'b1;
        #1;
        check_out("async_clear", 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        check_out("reset_held", 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        apply("post_rst1", mk(1,0,8'h01,4'h0,8'h00,8'h00,8'h00,8'h00));
        apply("post_rst2", mk(1,0,8'h02,4'h0,8'h00,8'h00,8'h00,8'h00));
        apply("post_rst3", mk(1,0,8'h03,4'h0,8'h00,8'h00,8'h00,8'h00));
        apply("post_rst4", mk(1,0,8'h04,4'hF,8'h01,8'h02,8'h03,8'h04));
        apply("post_rst_idle", mk(0,0,8'h00,4'h0,8'h01,8'h02,8'h03,8'h04));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
